// File: rtl/ex_madd_seq_if.sv
// EX-stage multiply-accumulate port bundle: opcode/operands/forwarded HI-LO in,
// stall request and HI/LO result out.
interface ex_madd_seq_if;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        hold_i;
    logic        stallreq_o;
    logic [63:0] hilo_o;
    logic        whilo_o;
    logic [1:0]  cnt_o;

    modport master (
        output aluop_i, reg1_i, reg2_i, hi_i, lo_i, hold_i,
        input  stallreq_o, hilo_o, whilo_o, cnt_o
    );

    modport slave (
        input  aluop_i, reg1_i, reg2_i, hi_i, lo_i, hold_i,
        output stallreq_o, hilo_o, whilo_o, cnt_o
    );
endinterface

// File: rtl/ex_madd_seq.sv
// Multi-cycle MADD/MADDU/MSUB/MSUBU sequencer (IDLE -> MUL -> ACC -> DONE).
// Define MADD_MULT_ITER_EN for a 32-cycle radix-2 shift-add multiplier instead of a single-cycle one.
module ex_madd_seq (
    input  logic         clk,
    input  logic         rst,
    ex_madd_seq_if.slave bus
);
    localparam int unsigned REG_W  = 32;
    localparam int unsigned DREG_W = 64;
    localparam int unsigned OP_W   = 8;

    localparam logic [OP_W-1:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [OP_W-1:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [OP_W-1:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [OP_W-1:0] EXE_MSUBU_OP = 8'b1010_1011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        ACC  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t             state;
    logic [REG_W-1:0]   op1_q;
    logic [REG_W-1:0]   op2_q;
    logic [DREG_W-1:0]  acc_q;
    logic [DREG_W-1:0]  prod_q;
    logic               signed_q;
    logic               sub_q;

    logic               is_madd_c;
    logic               op_signed_c;
    logic               op_sub_c;
    logic               mul_done_c;
    logic [DREG_W-1:0]  mul_next_c;

    // Opcode decode
    always_comb begin
        op_signed_c = (bus.aluop_i == EXE_MADD_OP) || (bus.aluop_i == EXE_MSUB_OP);
        op_sub_c    = (bus.aluop_i == EXE_MSUB_OP) || (bus.aluop_i == EXE_MSUBU_OP);
        is_madd_c   = op_signed_c || op_sub_c || (bus.aluop_i == EXE_MADDU_OP);
    end

`ifdef MADD_MULT_ITER_EN
    logic [4:0]        iter_q;
    logic [REG_W-1:0]  mag1_c;
    logic [REG_W-1:0]  mag2_c;
    logic [DREG_W-1:0] partial_c;
    logic [DREG_W-1:0] sum_c;
    logic              neg_c;

    // Magnitude shift-add; sign is restored on the final iteration
    always_comb begin
        mag1_c     = (signed_q && op1_q[REG_W-1]) ? (~op1_q + 32'd1) : op1_q;
        mag2_c     = (signed_q && op2_q[REG_W-1]) ? (~op2_q + 32'd1) : op2_q;
        neg_c      = signed_q && (op1_q[REG_W-1] ^ op2_q[REG_W-1]);
        partial_c  = mag2_c[iter_q] ? (DREG_W'(mag1_c) << iter_q) : '0;
        sum_c      = prod_q + partial_c;
        mul_done_c = (iter_q == 5'd31);
        mul_next_c = (mul_done_c && neg_c) ? (~sum_c + 64'd1) : sum_c;
    end
`else
    logic [DREG_W-1:0] ext1_c;
    logic [DREG_W-1:0] ext2_c;

    // Sign/zero-extend to 64 bits; the low 64 bits of the product are exact either way
    always_comb begin
        ext1_c     = signed_q ? {{REG_W{op1_q[REG_W-1]}}, op1_q} : DREG_W'(op1_q);
        ext2_c     = signed_q ? {{REG_W{op2_q[REG_W-1]}}, op2_q} : DREG_W'(op2_q);
        mul_next_c = ext1_c * ext2_c;
        mul_done_c = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op1_q       <= '0;
            op2_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            signed_q    <= 1'b0;
            sub_q       <= 1'b0;
            bus.hilo_o  <= '0;
            bus.whilo_o <= 1'b0;
`ifdef MADD_MULT_ITER_EN
            iter_q      <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_madd_c) begin
                        op1_q    <= bus.reg1_i;
                        op2_q    <= bus.reg2_i;
                        acc_q    <= {bus.hi_i, bus.lo_i};
                        signed_q <= op_signed_c;
                        sub_q    <= op_sub_c;
                        prod_q   <= '0;
`ifdef MADD_MULT_ITER_EN
                        iter_q   <= '0;
`endif
                        state    <= MUL;
                    end
                end
                MUL: begin
                    prod_q <= mul_next_c;
`ifdef MADD_MULT_ITER_EN
                    iter_q <= 5'(iter_q + 5'd1);
`endif
                    if (mul_done_c) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    bus.hilo_o  <= sub_q ? (acc_q - prod_q) : (acc_q + prod_q);
                    bus.whilo_o <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (!bus.hold_i) begin
                        bus.whilo_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    // Stall is combinational in IDLE so the issuing cycle is held too
    always_comb begin
        bus.stallreq_o = 1'b0;
        case (state)
            IDLE:    bus.stallreq_o = is_madd_c;
            MUL:     bus.stallreq_o = 1'b1;
            ACC:     bus.stallreq_o = 1'b1;
            default: bus.stallreq_o = 1'b0;
        endcase
    end

    assign bus.cnt_o = state;

endmodule

// File: tb/tb_ex_madd_seq.sv
// Bench for ex_madd_seq: fixed vectors, random ops against an arithmetic model,
// hold and mid-operation reset sequences.
module tb_ex_madd_seq;
    localparam logic [7:0] OP_MADD  = 8'b1010_0110;
    localparam logic [7:0] OP_MADDU = 8'b1010_1000;
    localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
    localparam logic [7:0] OP_MSUBU = 8'b1010_1011;
    localparam logic [7:0] OP_ADD   = 8'b0010_0000;
    localparam logic [7:0] OP_NOP   = 8'b0000_0000;
`ifdef MADD_MULT_ITER_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        logic [7:0]  op;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    ex_madd_seq_if bus ();

    ex_madd_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definition
    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] r1,
                                          input logic [31:0] r2, input logic [31:0] hi,
                                          input logic [31:0] lo);
        logic [63:0] p;
        logic [63:0] acc;
        acc = {hi, lo};
        if (op == OP_MADD || op == OP_MSUB)
            p = 64'(longint'(int'(r1)) * longint'(int'(r2)));
        else
            p = 64'(r1) * 64'(r2);
        return (op == OP_MSUB || op == OP_MSUBU) ? acc - p : acc + p;
    endfunction

    // Issue one op from IDLE at posedge+1 and follow it through DONE back to IDLE
    task automatic run_op(input logic [7:0] op, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] hi, input logic [31:0] lo,
                          input logic [63:0] exp, input int hold_cycles);
        int n;
        bus.aluop_i = op;
        bus.reg1_i  = r1;
        bus.reg2_i  = r2;
        bus.hi_i    = hi;
        bus.lo_i    = lo;
        bus.hold_i  = (hold_cycles > 0);
        #1;
        chk("stall_issue", 64'(bus.stallreq_o), 64'd1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (bus.cnt_o != 2'b11 && bus.stallreq_o !== 1'b1)
                chk("stall_busy", 64'(bus.stallreq_o), 64'd1);
        end while (bus.cnt_o != 2'b11 && n < 200);
        chk("latency", 64'(n), 64'(LAT));
        chk("done_whilo", 64'(bus.whilo_o), 64'd1);
        chk("done_hilo", bus.hilo_o, exp);
        chk("done_stall", 64'(bus.stallreq_o), 64'd0);
        for (int k = 0; k < hold_cycles; k++) begin
            @(posedge clk);
            #1;
            chk("hold_cnt", 64'(bus.cnt_o), 64'd3);
            chk("hold_whilo", 64'(bus.whilo_o), 64'd1);
            chk("hold_hilo", bus.hilo_o, exp);
            chk("hold_stall", 64'(bus.stallreq_o), 64'd0);
        end
        bus.hold_i = 1'b0;
        @(posedge clk);
        #1;
        chk("exit_cnt", 64'(bus.cnt_o), 64'd0);
        chk("exit_whilo", 64'(bus.whilo_o), 64'd0);
        chk("idle_hilo_kept", bus.hilo_o, exp);
        bus.aluop_i = OP_NOP;
        #1;
        chk("idle_stall", 64'(bus.stallreq_o), 64'd0);
    endtask

    vec_t vecs[4];
    logic [7:0]  ops[4];
    logic [31:0] edge_vals[4];

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0)
            return edge_vals[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        vecs[0] = '{OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 64'hFFFF_FFFE_0000_0002};
        vecs[1] = '{OP_MADD,  32'hFFFF_FFFF, 32'h2,         32'h0, 32'h5, 64'h0000_0000_0000_0003};
        vecs[2] = '{OP_MSUB,  32'h3,         32'h4,         32'h0, 32'hA, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[3] = '{OP_MSUBU, 32'h1,         32'h1,         32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        ops[0] = OP_MADD;  ops[1] = OP_MADDU; ops[2] = OP_MSUB; ops[3] = OP_MSUBU;
        edge_vals[0] = 32'h8000_0000; edge_vals[1] = 32'h0;
        edge_vals[2] = 32'hFFFF_FFFF; edge_vals[3] = 32'h7FFF_FFFF;

        bus.aluop_i = OP_NOP;
        bus.reg1_i  = '0;
        bus.reg2_i  = '0;
        bus.hi_i    = '0;
        bus.lo_i    = '0;
        bus.hold_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", 64'(bus.cnt_o), 64'd0);
        chk("rst_hilo", bus.hilo_o, 64'd0);
        chk("rst_whilo", 64'(bus.whilo_o), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Non-accumulate opcode leaves the block idle
        bus.aluop_i = OP_ADD;
        #1;
        chk("add_stall", 64'(bus.stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        chk("add_cnt", 64'(bus.cnt_o), 64'd0);
        bus.aluop_i = OP_NOP;

        for (int i = 0; i < 4; i++)
            run_op(vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].hi, vecs[i].lo, vecs[i].exp, 0);

        // Hold for three DONE cycles
        run_op(vecs[0].op, vecs[0].r1, vecs[0].r2, vecs[0].hi, vecs[0].lo, vecs[0].exp, 3);

        for (int i = 0; i < 30; i++) begin
            logic [7:0]  op;
            logic [31:0] r1, r2, hi, lo;
            op = ops[$urandom_range(0, 3)];
            r1 = pick_operand();
            r2 = pick_operand();
            hi = $urandom;
            lo = $urandom;
            run_op(op, r1, r2, hi, lo, model(op, r1, r2, hi, lo), (i % 7 == 3) ? 2 : 0);
        end

        // Reset pulsed in MUL discards the operation
        bus.aluop_i = OP_MADD;
        bus.reg1_i  = 32'h1234_5678;
        bus.reg2_i  = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        chk("mid_mul_cnt", 64'(bus.cnt_o), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_cnt", 64'(bus.cnt_o), 64'd0);
        chk("mid_rst_hilo", bus.hilo_o, 64'd0);
        chk("mid_rst_whilo", 64'(bus.whilo_o), 64'd0);
        #1;
        rst = 1'b1;
        bus.aluop_i = OP_ADD;
        #1;
        chk("post_rst_stall", 64'(bus.stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        chk("post_rst_cnt", 64'(bus.cnt_o), 64'd0);
        chk("post_rst_whilo", 64'(bus.whilo_o), 64'd0);
        bus.aluop_i = OP_NOP;

        run_op(vecs[2].op, vecs[2].r1, vecs[2].r2, vecs[2].hi, vecs[2].lo, vecs[2].exp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ex_madd_seq.md
# ex_madd_seq

Multi-cycle multiply-accumulate sequencer for the EX stage. It executes MADD, MADDU, MSUB and MSUBU, holding the partial product and accumulation state internally across cycles. It stalls the pipeline through `stallreq_o` and presents the 64-bit HI/LO result to the EX/MEM latch once the result is complete. It is the producing end of the multi-cycle HI/LO accumulation path whose intermediate state the EX/MEM register carries.

## Interface
Parameters:
- none; widths come from `RegBus` (32) and `DoubleRegBus` (64) in define.v.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low: asserted when 0.
- `aluop_i`  in  8  EX opcode; only `EXE_MADD_OP`, `EXE_MADDU_OP`, `EXE_MSUB_OP` and `EXE_MSUBU_OP` act on this block.
- `reg1_i`  in  32  multiplicand.
- `reg2_i`  in  32  multiplier.
- `hi_i`  in  32  forwarded HI, sampled at accept.
- `lo_i`  in  32  forwarded LO, sampled at accept.
- `hold_i`  in  1  downstream stall (stall[4]); freezes the DONE state.
- `stallreq_o`  out  1  EX stall request.
- `hilo_o`  out  64  accumulated {HI,LO} result.
- `whilo_o`  out  1  result valid; the HI/LO write enable for the instruction.
- `cnt_o`  out  2  state encoding: IDLE=00, MUL=01, ACC=10, DONE=11.

## Operation
- Reset (rst=0, any cycle, including mid-operation):
  - state=IDLE, `hilo_o`=0, `whilo_o`=0, all internal registers cleared.
  - The in-flight operation is discarded and produces no write.
- IDLE:
  - `stallreq_o` is combinational: 1 iff `aluop_i` is one of the four ops.
  - On an edge with such an op, latch `reg1_i`, `reg2_i`, `hi_i`, `lo_i`, signed flag (MADD/MSUB) and subtract flag (MSUB/MSUBU); go to MUL.
- MUL: `stallreq_o`=1.
  - The product is computed into a 64-bit register.
  - Signed ops: full two's-complement 32×32→64.
  - Unsigned ops: zero-extended operands.
  - Go to ACC when the product is final.
- ACC: `stallreq_o`=1.
  - `hilo_o` <= {hi,lo} + product, or {hi,lo} − product for the MSUB ops.
  - Arithmetic is modulo 2^64; no overflow or trap.
  - Go to DONE.
- DONE: `stallreq_o`=0, `whilo_o`=1 (registered; high exactly while in DONE).
  - `hold_i`=1: stay in DONE, outputs stable.
  - `hold_i`=0: go to IDLE.
  - The op present on `aluop_i` in the DONE cycle is never re-accepted.
- `hilo_o` retains its last value in IDLE; only `whilo_o` qualifies it.
- Non-MADD opcodes in IDLE: `stallreq_o`=0, no state change.

## Timing
- The op is presented in cycle 0 (IDLE).
- Without iteration:
  - MUL is cycle 1, ACC is cycle 2, DONE is cycle 3.
  - `stallreq_o` is high in cycles 0–2 and low in cycle 3.
  - EX/MEM captures the result at the end of cycle 3.
  - Minimum occupancy is 4 cycles.
- With `MADD_MULT_ITER_EN`: MUL lasts 32 cycles (cycles 1–32), ACC is cycle 33, DONE is cycle 34.
- Back-to-back ops: the next op is accepted in the IDLE cycle after DONE. There is no overlap.
- `hold_i` is ignored outside DONE; the EX stall already holds the inputs.

## Configuration
- `MADD_MULT_ITER_EN` undefined: single-cycle combinational 32×32 multiplier in MUL.
- `MADD_MULT_ITER_EN` defined: radix-2 shift-add multiplier.
  - Operates on operand magnitudes (unsigned ops use the raw value).
  - A 5-bit iteration counter counts 0..31; MUL exits when the count is 31.
  - The product is negated after the last iteration when the signed flag is set and the operand signs differ.
  - Results are bit-identical to the non-iterative build.

## Test plan
- MADDU: reg1=0xFFFFFFFF, reg2=0xFFFFFFFF, hi=0, lo=1 -> `hilo_o`=0xFFFFFFFE_00000002 with `whilo_o`=1 in cycle 3 (cycle 34 iterative).
- MADD: reg1=0xFFFFFFFF (−1), reg2=2, hi=0, lo=5 -> `hilo_o`=0x00000000_00000003.
- MSUB: reg1=3, reg2=4, hi=0, lo=10 -> `hilo_o`=0xFFFFFFFF_FFFFFFFE.
- MSUBU wrap: reg1=1, reg2=1, hi=0, lo=0 -> `hilo_o`=0xFFFFFFFF_FFFFFFFF.
- `hold_i`=1 for the first 3 DONE cycles -> `whilo_o` high 4 cycles, `hilo_o` stable, `stallreq_o`=0 throughout, `cnt_o`=11, then IDLE.
- rst pulsed low during MUL -> immediately `cnt_o`=00, `hilo_o`=0, `whilo_o`=0. The next cycle with ADD on `aluop_i` gives `stallreq_o`=0.
